fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues word-aligned fetches, tags in-flight PCs,
// buffers returned instructions for decode, and flushes/refetches on redirect.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc
);

  localparam int          AW   = $clog2(QDEPTH);
  localparam int          CW   = AW + 1;
  localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic            started;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [AW-1:0]   tag_wr, tag_rd;
  logic [AW-1:0]   q_wr, q_rd;

  logic [XLEN-1:0] tag_mem [QDEPTH];
  logic [XLEN-1:0] q_pc    [QDEPTH];
  logic [31:0]     q_instr [QDEPTH];

  logic            req_fire;
  logic            rsp_drop;
  logic            enq;
  logic            deq;
  logic [CW:0]     reserved;
  logic [XLEN-1:0] redirect_aligned;

  // Every queue slot is reserved at request time, so a response always has room.
  assign reserved         = {1'b0, occ} + {1'b0, inflight};
  assign imem_req_valid   = started && !redirect_valid && (reserved < QLIM);
  assign imem_req_addr    = fetch_pc & ~XLEN'(3);
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign enq      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign deq      = dec_valid && dec_ready && !redirect_valid;

  assign dec_valid = (occ != '0);
  assign dec_instr = q_instr[q_rd];
  assign dec_pc    = q_pc[q_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      started  <= 1'b0;
      occ      <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
    end else begin
      started  <= 1'b1;
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        fetch_pc <= redirect_aligned;
        drop_cnt <= inflight - CW'(imem_rsp_valid);
        occ      <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
        q_wr     <= '0;
        q_rd     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          tag_wr   <= tag_wr + AW'(1);
        end
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (enq) begin
          q_wr   <= q_wr + AW'(1);
          tag_rd <= tag_rd + AW'(1);
        end
        if (deq) q_rd <= q_rd + AW'(1);
        occ <= occ + CW'(enq) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= imem_req_addr;
    if (enq) begin
      q_pc[q_wr]    <= tag_mem[tag_rd];
      q_instr[q_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model with configurable latency and a
// scoreboard of expected {pc, instr} pairs checked at every decode handshake.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  fetch_queue #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct packed { logic [31:0] due; logic [31:0] addr; } pend_t;

  exp_t  sb[$];
  pend_t pend[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  int req_count = 0;
  int deq_count = 0;
  int wrap_hits = 0;
  bit rand_mode = 1'b0;
  bit stalled = 1'b0;
  bit check_flush = 1'b0;
  bit first_watch = 1'b0;
  bit wrap_watch = 1'b0;
  bit done = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] stall_addr = 32'h0;
  logic [31:0] first_target = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired before test completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Sampled at the falling edge, with this cycle's inputs already applied.
  task automatic evaluate();
    exp_t e;
    if (check_flush) begin
      chk("flush_empties_queue", dec_valid, 1'b0);
      check_flush = 1'b0;
    end
    if (stalled && imem_req_valid) chk("addr_hold_on_stall", imem_req_addr, stall_addr);
    stalled    = imem_req_valid && !imem_req_ready;
    stall_addr = imem_req_addr;
    if (redirect_valid) begin
      chk("no_req_during_redirect", imem_req_valid, 1'b0);
      sb.delete();
      exp_pc       = {redirect_pc[31:2], 2'b00};
      first_target = exp_pc;
      first_watch  = 1'b1;
      check_flush  = 1'b1;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_pc);
        if (wrap_watch && exp_pc == 32'h0) begin
          chk("wrap_addr", imem_req_addr, 32'h0);
          wrap_hits++;
          wrap_watch = 1'b0;
        end
        pend.push_back('{due: 32'(cyc + lat), addr: imem_req_addr});
        sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        req_count++;
      end
      if (dec_valid && dec_ready) begin
        chk("output_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("dec_pc", dec_pc, e.pc);
          chk("dec_instr", dec_instr, e.instr);
        end
        if (first_watch) begin
          chk("first_pc_after_redirect", dec_pc, first_target);
          first_watch = 1'b0;
        end
        deq_count++;
      end
    end
  endtask

  task automatic tick();
    pend_t p;
    @(negedge clk);
    if (!rst) evaluate();
    @(posedge clk);
    cyc++;
    #1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() != 0 && pend[0].due <= 32'(cyc)) begin
      p = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(p.addr);
    end
    if (rand_mode) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      dec_ready      = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    dec_ready = 1'b0;
    #3;
    chk("reset_dec_valid", dec_valid, 1'b0);
    chk("reset_req_valid", imem_req_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Sustained streaming with a one-cycle memory.
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    lat = 1;
    repeat (5) tick();
    deq_count = 0;
    req_count = 0;
    repeat (10) tick();
    chk("stream_deq_rate", deq_count, 10);
    chk("stream_req_rate", req_count, 10);

    // Drain, then fill with decode stalled.
    imem_req_ready = 1'b0;
    repeat (6) tick();
    req_count = 0;
    imem_req_ready = 1'b1;
    dec_ready = 1'b0;
    repeat (10) tick();
    chk("fill_req_count", req_count, 4);
    #1;
    chk("full_req_valid", imem_req_valid, 1'b0);
    chk("full_dec_valid", dec_valid, 1'b1);
    dec_ready = 1'b1;
    repeat (10) tick();

    // Redirect with two requests outstanding.
    lat = 2;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    repeat (8) tick();
    chk("first_after_redirect_seen", first_watch, 1'b0);

    // Address wrap at the top of the address space.
    wrap_hits = 0;
    wrap_watch = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF4;
    tick();
    repeat (8) tick();
    chk("wrap_seen", wrap_hits, 1);

    // Randomly stalling memory and decode with a three-cycle memory.
    lat = 3;
    rand_mode = 1'b1;
    repeat (60) tick();
    rand_mode = 1'b0;

    // Asynchronous reset while the queue is full.
    lat = 1;
    imem_req_ready = 1'b1;
    dec_ready = 1'b0;
    repeat (10) tick();
    #1;
    chk("prereset_dec_valid", dec_valid, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_dec_valid", dec_valid, 1'b0);
    chk("async_reset_req_valid", imem_req_valid, 1'b0);
    pend.delete();
    sb.delete();
    imem_rsp_valid = 1'b0;
    exp_pc = 32'h0;
    stalled = 1'b0;
    check_flush = 1'b0;
    first_watch = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    dec_ready = 1'b1;
    repeat (10) tick();

    imem_req_ready = 1'b0;
    repeat (30) tick();
    chk("scoreboard_drained", sb.size(), 0);

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
